regfile_tag_tracker: RTL and testbench
======================================

Name: regfile_tag_tracker

Overview:
- Architectural register file for the out-of-order core, with per-register busy/tag tracking in Tomasulo style.
- Dispatch marks a destination register busy and records the ROB tag that will produce it.
- Commit writes the result value, and clears busy only if the committing tag still owns the register.
- Two combinational read ports feed operand fetch at dispatch; same-cycle commit data is bypassed onto them.

Parameters:
- WIDTH, 16, data width of each register.
- NUM_REGS, 8, number of architectural registers; address width AW = $clog2(NUM_REGS).
- TAG_WIDTH, 3, ROB tag width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr_a  in  AW  read port A register index.
- rd_data_a  out  WIDTH  register A value (or bypassed commit value).
- rd_busy_a  out  1  register A awaiting result.
- rd_tag_a  out  TAG_WIDTH  ROB tag producing register A (valid when rd_busy_a=1).
- rd_addr_b, rd_data_b, rd_busy_b, rd_tag_b: same as port A, for read port B.
- dispatch_valid  in  1  allocate destination this cycle.
- dispatch_dest  in  AW  destination register.
- dispatch_tag  in  TAG_WIDTH  ROB tag of the dispatching instruction.
- commit_valid  in  1  retire a result this cycle.
- commit_dest  in  AW  register written by the retiring instruction.
- commit_tag  in  TAG_WIDTH  ROB tag of the retiring instruction.
- commit_data  in  WIDTH  result value.
- flush  in  1  pipeline flush (mispredict).

Behaviour:
- State per register: data[WIDTH], busy[1], tag[TAG_WIDTH].
- Reset (rst_n=0, asynchronous, takes effect immediately): all data=0, busy=0, tag=0. While in reset, every read output is 0.
- All state updates occur at posedge clk. Reads are combinational (0-cycle latency).
- Commit, when commit_valid=1:
  - data[commit_dest] <= commit_data, unconditionally (in-order retire).
  - busy[commit_dest] <= 0 only if busy[commit_dest]=1, tag[commit_dest]==commit_tag, and there is no same-cycle dispatch to commit_dest.
  - Otherwise busy and tag of commit_dest are unchanged.
- Dispatch, when dispatch_valid=1: busy[dispatch_dest] <= 1 and tag[dispatch_dest] <= dispatch_tag. Dispatch has priority over the commit busy-clear.
- Dispatch and commit to the same register in the same cycle:
  - data takes commit_data.
  - busy=1 and tag=dispatch_tag after the edge, regardless of tag match.
- Flush=1: all busy bits <= 0 at the edge; data and tag are unchanged.
  - Same-cycle commit still writes its data.
  - Same-cycle dispatch is ignored (flush wins).
- Read ports, evaluated independently for A and B:
  - Base case: rd_data_x=data[addr], rd_busy_x=busy[addr], rd_tag_x=tag[addr].
  - Bypass case: if commit_valid, commit_dest==addr, busy[addr]=1 and tag[addr]==commit_tag, then rd_data_x=commit_data and rd_busy_x=0.
  - Dispatch in the same cycle is NOT visible on the read ports; reads reflect state before the edge. The dispatcher resolves intra-bundle dependencies itself.
- Stale commit (tag mismatch, or register not busy): data still updates. No bypass occurs and busy is held.
- Address range: indices >= NUM_REGS are not generated by the design; behaviour for them is unspecified.

Test Plan:
- Reset, then read R0..R7 on both ports -> data=0x0000, busy=0 for all; assert rst_n mid-run -> outputs return to 0 asynchronously, before the next clock edge.
- Dispatch R3 tag=5; next cycle commit R3 tag=5 data=0xBEEF -> during the commit cycle port A (addr 3) shows 0xBEEF, busy=0 (bypass); after the edge data=0xBEEF, busy=0.
- Dispatch R2 tag=1, then dispatch R2 tag=4, then commit R2 tag=1 data=0x1234 -> after the commit edge data=0x1234, busy=1, tag=4; read during the commit cycle shows busy=1, tag=4 with no bypass.
- Same cycle: commit R5 tag=2 data=0x00AA plus dispatch R5 tag=6 (R5 busy with tag 2) -> after the edge data=0x00AA, busy=1, tag=6.
- Dispatch R1 tag=3 and R6 tag=7, then flush with a simultaneous dispatch R4 tag=0 -> after the edge busy=0 for R1, R4 and R6; tags of R1 and R6 unchanged (3 and 7).
- Both ports read the same committing register R7 (busy, tag=2, commit data=0xFFFF) -> both ports show 0xFFFF, busy=0.

Source files
------------

// File: rtl/regfile_tag_tracker.sv
// Architectural register file with per-register busy/ROB-tag tracking.
// Dispatch claims a destination, commit writes data and releases it if the tag still owns it.
module regfile_tag_tracker #(
  parameter int WIDTH     = 16,
  parameter int NUM_REGS  = 8,
  parameter int TAG_WIDTH = 3,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic [AW-1:0]        rd_addr_a,
  output logic [WIDTH-1:0]     rd_data_a,
  output logic                 rd_busy_a,
  output logic [TAG_WIDTH-1:0] rd_tag_a,

  input  logic [AW-1:0]        rd_addr_b,
  output logic [WIDTH-1:0]     rd_data_b,
  output logic                 rd_busy_b,
  output logic [TAG_WIDTH-1:0] rd_tag_b,

  input  logic                 dispatch_valid,
  input  logic [AW-1:0]        dispatch_dest,
  input  logic [TAG_WIDTH-1:0] dispatch_tag,

  input  logic                 commit_valid,
  input  logic [AW-1:0]        commit_dest,
  input  logic [TAG_WIDTH-1:0] commit_tag,
  input  logic [WIDTH-1:0]     commit_data,

  input  logic                 flush
);

  logic [WIDTH-1:0]     data_q [NUM_REGS];
  logic [TAG_WIDTH-1:0] tag_q  [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;

  logic commit_owns;
  logic dispatch_hits_commit;

  assign commit_owns          = busy_q[commit_dest] && (tag_q[commit_dest] == commit_tag);
  assign dispatch_hits_commit = dispatch_valid && (dispatch_dest == commit_dest);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      // Retire is in order, so the data write never depends on ownership.
      if (commit_valid) begin
        data_q[commit_dest] <= commit_data;
      end
      if (flush) begin
        busy_q <= '0;
      end else begin
        if (commit_valid && commit_owns && !dispatch_hits_commit) begin
          busy_q[commit_dest] <= 1'b0;
        end
        if (dispatch_valid) begin
          busy_q[dispatch_dest] <= 1'b1;
          tag_q[dispatch_dest]  <= dispatch_tag;
        end
      end
    end
  end

  // Read ports show pre-edge state; only an owning commit is bypassed, never a dispatch.
  always_comb begin
    rd_data_a = '0;
    rd_busy_a = 1'b0;
    rd_tag_a  = '0;
    if (rst_n) begin
      rd_data_a = data_q[rd_addr_a];
      rd_busy_a = busy_q[rd_addr_a];
      rd_tag_a  = tag_q[rd_addr_a];
      if (commit_valid && (commit_dest == rd_addr_a) && busy_q[rd_addr_a] &&
          (tag_q[rd_addr_a] == commit_tag)) begin
        rd_data_a = commit_data;
        rd_busy_a = 1'b0;
      end
    end
  end

  always_comb begin
    rd_data_b = '0;
    rd_busy_b = 1'b0;
    rd_tag_b  = '0;
    if (rst_n) begin
      rd_data_b = data_q[rd_addr_b];
      rd_busy_b = busy_q[rd_addr_b];
      rd_tag_b  = tag_q[rd_addr_b];
      if (commit_valid && (commit_dest == rd_addr_b) && busy_q[rd_addr_b] &&
          (tag_q[rd_addr_b] == commit_tag)) begin
        rd_data_b = commit_data;
        rd_busy_b = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_tag_tracker.sv
// Directed bench for regfile_tag_tracker: reset, bypass, stale commit,
// dispatch/commit collision, flush and dual-port reads.
module tb_regfile_tag_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_busy_a, rd_busy_b;
  logic [2:0]  rd_tag_a, rd_tag_b;
  logic        dispatch_valid;
  logic [2:0]  dispatch_dest, dispatch_tag;
  logic        commit_valid;
  logic [2:0]  commit_dest, commit_tag;
  logic [15:0] commit_data;
  logic        flush;

  int total = 0;
  int bad   = 0;

  regfile_tag_tracker #(.WIDTH(16), .NUM_REGS(8), .TAG_WIDTH(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_addr_a      (rd_addr_a),
    .rd_data_a      (rd_data_a),
    .rd_busy_a      (rd_busy_a),
    .rd_tag_a       (rd_tag_a),
    .rd_addr_b      (rd_addr_b),
    .rd_data_b      (rd_data_b),
    .rd_busy_b      (rd_busy_b),
    .rd_tag_b       (rd_tag_b),
    .dispatch_valid (dispatch_valid),
    .dispatch_dest  (dispatch_dest),
    .dispatch_tag   (dispatch_tag),
    .commit_valid   (commit_valid),
    .commit_dest    (commit_dest),
    .commit_tag     (commit_tag),
    .commit_data    (commit_data),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    commit_valid   = 1'b0;
    flush          = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    rd_addr_a      = '0;
    rd_addr_b      = '0;
    dispatch_valid = 1'b0;
    dispatch_dest  = '0;
    dispatch_tag   = '0;
    commit_valid   = 1'b0;
    commit_dest    = '0;
    commit_tag     = '0;
    commit_data    = '0;
    flush          = 1'b0;

    #2;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      #1;
      check($sformatf("rst_data_a_r%0d", i), 32'(rd_data_a), 32'h0);
      check($sformatf("rst_busy_a_r%0d", i), 32'(rd_busy_a), 32'h0);
      check($sformatf("rst_data_b_r%0d", 7 - i), 32'(rd_data_b), 32'h0);
      check($sformatf("rst_busy_b_r%0d", 7 - i), 32'(rd_busy_b), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Dispatch R3 tag 5, then commit it: bypass visible during the commit cycle.
    dispatch_valid = 1'b1; dispatch_dest = 3'd3; dispatch_tag = 3'd5;
    tick();
    idle();
    rd_addr_a = 3'd3;
    #1;
    check("r3_busy_after_dispatch", 32'(rd_busy_a), 32'h1);
    check("r3_tag_after_dispatch", 32'(rd_tag_a), 32'h5);
    commit_valid = 1'b1; commit_dest = 3'd3; commit_tag = 3'd5; commit_data = 16'hBEEF;
    #1;
    check("r3_bypass_data", 32'(rd_data_a), 32'hBEEF);
    check("r3_bypass_busy", 32'(rd_busy_a), 32'h0);
    tick();
    idle();
    #1;
    check("r3_data_after_commit", 32'(rd_data_a), 32'hBEEF);
    check("r3_busy_after_commit", 32'(rd_busy_a), 32'h0);

    // R2 renamed twice; the older commit writes data but leaves ownership with tag 4.
    dispatch_valid = 1'b1; dispatch_dest = 3'd2; dispatch_tag = 3'd1;
    tick();
    dispatch_tag = 3'd4;
    tick();
    idle();
    rd_addr_a = 3'd2;
    commit_valid = 1'b1; commit_dest = 3'd2; commit_tag = 3'd1; commit_data = 16'h1234;
    #1;
    check("r2_stale_no_bypass_data", 32'(rd_data_a), 32'h0);
    check("r2_stale_no_bypass_busy", 32'(rd_busy_a), 32'h1);
    check("r2_stale_tag", 32'(rd_tag_a), 32'h4);
    tick();
    idle();
    #1;
    check("r2_data_after_stale", 32'(rd_data_a), 32'h1234);
    check("r2_busy_after_stale", 32'(rd_busy_a), 32'h1);
    check("r2_tag_after_stale", 32'(rd_tag_a), 32'h4);

    // Commit to an idle register: data written, no bypass, busy stays 0.
    rd_addr_b = 3'd0;
    commit_valid = 1'b1; commit_dest = 3'd0; commit_tag = 3'd0; commit_data = 16'h0042;
    #1;
    check("r0_idle_no_bypass", 32'(rd_data_b), 32'h0);
    tick();
    idle();
    #1;
    check("r0_idle_data", 32'(rd_data_b), 32'h0042);
    check("r0_idle_busy", 32'(rd_busy_b), 32'h0);

    // R5: owning commit and new dispatch in the same cycle.
    dispatch_valid = 1'b1; dispatch_dest = 3'd5; dispatch_tag = 3'd2;
    tick();
    idle();
    rd_addr_a = 3'd5;
    commit_valid = 1'b1; commit_dest = 3'd5; commit_tag = 3'd2; commit_data = 16'h00AA;
    dispatch_valid = 1'b1; dispatch_dest = 3'd5; dispatch_tag = 3'd6;
    #1;
    check("r5_collide_read_data", 32'(rd_data_a), 32'h00AA);
    check("r5_collide_read_busy", 32'(rd_busy_a), 32'h0);
    check("r5_collide_read_tag", 32'(rd_tag_a), 32'h2);
    tick();
    idle();
    #1;
    check("r5_data_after_collide", 32'(rd_data_a), 32'h00AA);
    check("r5_busy_after_collide", 32'(rd_busy_a), 32'h1);
    check("r5_tag_after_collide", 32'(rd_tag_a), 32'h6);

    // Flush with a dispatch to R4 (ignored) and a commit to R1 (data still lands).
    dispatch_valid = 1'b1; dispatch_dest = 3'd1; dispatch_tag = 3'd3;
    tick();
    dispatch_dest = 3'd6; dispatch_tag = 3'd7;
    tick();
    dispatch_dest = 3'd4; dispatch_tag = 3'd0;
    flush = 1'b1;
    commit_valid = 1'b1; commit_dest = 3'd1; commit_tag = 3'd0; commit_data = 16'h5555;
    tick();
    idle();
    rd_addr_a = 3'd1; rd_addr_b = 3'd6;
    #1;
    check("r1_busy_after_flush", 32'(rd_busy_a), 32'h0);
    check("r1_tag_after_flush", 32'(rd_tag_a), 32'h3);
    check("r1_data_after_flush", 32'(rd_data_a), 32'h5555);
    check("r6_busy_after_flush", 32'(rd_busy_b), 32'h0);
    check("r6_tag_after_flush", 32'(rd_tag_b), 32'h7);
    rd_addr_a = 3'd4; rd_addr_b = 3'd5;
    #1;
    check("r4_busy_after_flush", 32'(rd_busy_a), 32'h0);
    check("r5_busy_after_flush", 32'(rd_busy_b), 32'h0);
    check("r5_tag_after_flush", 32'(rd_tag_b), 32'h6);

    // Both ports see the bypassed R7 commit.
    dispatch_valid = 1'b1; dispatch_dest = 3'd7; dispatch_tag = 3'd2;
    tick();
    idle();
    rd_addr_a = 3'd7; rd_addr_b = 3'd7;
    commit_valid = 1'b1; commit_dest = 3'd7; commit_tag = 3'd2; commit_data = 16'hFFFF;
    #1;
    check("r7_bypass_data_a", 32'(rd_data_a), 32'hFFFF);
    check("r7_bypass_busy_a", 32'(rd_busy_a), 32'h0);
    check("r7_bypass_data_b", 32'(rd_data_b), 32'hFFFF);
    check("r7_bypass_busy_b", 32'(rd_busy_b), 32'h0);
    tick();
    idle();

    // Mid-run asynchronous reset clears state and outputs before any edge.
    dispatch_valid = 1'b1; dispatch_dest = 3'd2; dispatch_tag = 3'd4;
    tick();
    idle();
    rd_addr_a = 3'd2; rd_addr_b = 3'd7;
    #1;
    check("r2_busy_before_rst", 32'(rd_busy_a), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_data_a", 32'(rd_data_a), 32'h0);
    check("async_rst_busy_a", 32'(rd_busy_a), 32'h0);
    check("async_rst_tag_a", 32'(rd_tag_a), 32'h0);
    check("async_rst_data_b", 32'(rd_data_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_data_r2", 32'(rd_data_a), 32'h0);
    check("post_rst_data_r7", 32'(rd_data_b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
